// File: rtl/rob_param_if.sv
// Bundle of decode, write-back, operand-check and commit signals around the reorder buffer.
// master = the surrounding pipeline, slave = the reorder buffer itself.
interface rob_param_if #(
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int BRA_W   = 8,
    parameter int NUM_CDB = 2
);
    logic                      alloc_valid;
    logic                      alloc_ready;
    logic [2:0]                alloc_op;
    logic [REG_W-1:0]          alloc_rd;
    logic [ADDR_W-1:0]         alloc_npc;
    logic [BRA_W-1:0]          alloc_baddr;
    logic [TAG_W-1:0]          alloc_tag;
    logic                      full;

    logic [TAG_W-1:0]          chk_tag1;
    logic [TAG_W-1:0]          chk_tag2;
    logic [DATA_W-1:0]         chk_val1;
    logic [DATA_W-1:0]         chk_val2;
    logic                      chk_rdy1;
    logic                      chk_rdy2;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic [NUM_CDB*ADDR_W-1:0] cdb_addr;

    logic                      bra_valid;
    logic [TAG_W-1:0]          bra_tag;
    logic                      bra_taken;
    logic                      bra_mispred;

    logic                      reg_modify;
    logic [REG_W-1:0]          reg_name;
    logic [DATA_W-1:0]         reg_data;
    logic [TAG_W-1:0]          reg_tag;

    logic                      dcache_write;
    logic [3:0]                dcache_mask;
    logic [ADDR_W-1:0]         dcache_addr;
    logic [DATA_W-1:0]         dcache_data;
    logic                      dcache_ready;

    logic                      pc_modify;
    logic [ADDR_W-1:0]         npc;

    logic                      brp_update;
    logic [BRA_W-1:0]          brp_addr;
    logic                      brp_result;

    modport master (
        output alloc_valid, alloc_op, alloc_rd, alloc_npc, alloc_baddr,
        output chk_tag1, chk_tag2,
        output cdb_valid, cdb_tag, cdb_value, cdb_addr,
        output bra_valid, bra_tag, bra_taken, bra_mispred,
        output dcache_ready,
        input  alloc_ready, alloc_tag, full,
        input  chk_val1, chk_val2, chk_rdy1, chk_rdy2,
        input  reg_modify, reg_name, reg_data, reg_tag,
        input  dcache_write, dcache_mask, dcache_addr, dcache_data,
        input  pc_modify, npc,
        input  brp_update, brp_addr, brp_result
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd, alloc_npc, alloc_baddr,
        input  chk_tag1, chk_tag2,
        input  cdb_valid, cdb_tag, cdb_value, cdb_addr,
        input  bra_valid, bra_tag, bra_taken, bra_mispred,
        input  dcache_ready,
        output alloc_ready, alloc_tag, full,
        output chk_val1, chk_val2, chk_rdy1, chk_rdy2,
        output reg_modify, reg_name, reg_data, reg_tag,
        output dcache_write, dcache_mask, dcache_addr, dcache_data,
        output pc_modify, npc,
        output brp_update, brp_addr, brp_result
    );
endinterface

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order commit of normal ops, stores and branches,
// CDB/branch write-back, two bypassed operand-check ports and mispredict flush.
module rob_param #(
    parameter int DEPTH   = 8,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 5,
    parameter int BRA_W   = 8,
    parameter int NUM_CDB = 2
) (
    input  logic       clk,
    input  logic       rst,
    rob_param_if.slave bus
);
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_NORMAL = 3'd2;
    localparam logic [2:0] OP_SB     = 3'd3;
    localparam logic [2:0] OP_SH     = 3'd4;
    localparam logic [2:0] OP_SW     = 3'd5;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [2:0]        op;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] npc;
        logic [BRA_W-1:0]  baddr;
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic              mispred;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              reg_modify_q, reg_modify_d;
    logic [REG_W-1:0]  reg_name_q, reg_name_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic [TAG_W-1:0]  reg_tag_q, reg_tag_d;
    logic              pc_modify_q, pc_modify_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic              brp_update_q, brp_update_d;
    logic [BRA_W-1:0]  brp_addr_q, brp_addr_d;
    logic              brp_result_q, brp_result_d;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_value;
    logic [NUM_CDB*ADDR_W-1:0] cdb_addr;

    entry_t      hd;
    logic        head_ok;
    logic        is_store;
    logic        st_aligned;
    logic        store_go;
    logic [3:0]  st_mask;
    logic [1:0]  lane;
    logic        retire;
    logic        flush;
    logic        full;
    logic        alloc_ready;
    logic        alloc_fire;

    assign cdb_valid = bus.cdb_valid;
    assign cdb_tag   = bus.cdb_tag;
    assign cdb_value = bus.cdb_value;
    assign cdb_addr  = bus.cdb_addr;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Lowest CDB channel wins, hence the descending scan.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
        logic [DATA_W:0] r;
        r = {ent_q[t].busy && ent_q[t].ready, ent_q[t].value};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == t))
                r = {1'b1, cdb_value[c*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    // ---------------- head / commit decode ----------------
    assign hd       = ent_q[head_q];
    assign head_ok  = (count_q != '0) && hd.busy && hd.ready;
    assign is_store = op_is_store(hd.op);
    assign lane     = hd.addr[1:0];

    always_comb begin
        st_aligned = 1'b0;
        st_mask    = 4'b0000;
        case (hd.op)
            OP_SB: begin
                st_aligned = 1'b1;
                st_mask    = 4'b0001 << lane;
            end
            OP_SH: begin
                st_aligned = !lane[0];
                st_mask    = lane[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                st_aligned = (lane == 2'b00);
                st_mask    = 4'b1111;
            end
            default: begin
                st_aligned = 1'b0;
                st_mask    = 4'b0000;
            end
        endcase
    end

    assign store_go = head_ok && is_store && st_aligned;
    // Misaligned stores and illegal ops drain without side effects so the queue never stalls.
    assign retire   = head_ok && (!store_go || bus.dcache_ready);
    assign flush    = retire && (hd.op == OP_BRANCH) && hd.mispred;

    assign full        = (count_q == (TAG_W+1)'(DEPTH));
    assign alloc_ready = !full && !flush;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;

    // ---------------- entry array next state ----------------
    always_comb begin : entry_next
        logic hit;
        hit = 1'b0;
        for (int e = 0; e < DEPTH; e++) ent_d[e] = ent_q[e];
        if (flush) begin
            for (int e = 0; e < DEPTH; e++) ent_d[e].busy = 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                hit = 1'b0;
                if (ent_q[e].busy && !ent_q[e].ready) begin
                    for (int c = 0; c < NUM_CDB; c++) begin
                        if (!hit && cdb_valid[c] &&
                            (cdb_tag[c*TAG_W +: TAG_W] == TAG_W'(e))) begin
                            hit            = 1'b1;
                            ent_d[e].ready = 1'b1;
                            ent_d[e].value = cdb_value[c*DATA_W +: DATA_W];
                            if (op_is_store(ent_q[e].op))
                                ent_d[e].addr = cdb_addr[c*ADDR_W +: ADDR_W];
                        end
                    end
                    if (!hit && bus.bra_valid && (bus.bra_tag == TAG_W'(e))) begin
                        ent_d[e].ready   = 1'b1;
                        ent_d[e].taken   = bus.bra_taken;
                        ent_d[e].mispred = bus.bra_mispred;
                    end
                end
            end
            if (retire)
                ent_d[head_q].busy = 1'b0;
            if (alloc_fire) begin
                ent_d[tail_q]       = '0;
                ent_d[tail_q].busy  = 1'b1;
                ent_d[tail_q].op    = bus.alloc_op;
                ent_d[tail_q].rd    = bus.alloc_rd;
                ent_d[tail_q].npc   = bus.alloc_npc;
                ent_d[tail_q].baddr = bus.alloc_baddr;
            end
        end
    end

    // ---------------- pointers / occupancy ----------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire)
            head_d = head_q + TAG_W'(1);
        if (flush) begin
            tail_d  = head_q + TAG_W'(1);
            count_d = '0;
        end else begin
            if (alloc_fire)
                tail_d = tail_q + TAG_W'(1);
            case ({alloc_fire, retire})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ---------------- registered commit outputs ----------------
    always_comb begin
        reg_modify_d = retire && (hd.op == OP_NORMAL);
        reg_name_d   = reg_name_q;
        reg_data_d   = reg_data_q;
        reg_tag_d    = reg_tag_q;
        if (reg_modify_d) begin
            reg_name_d = hd.rd;
            reg_data_d = hd.value;
            reg_tag_d  = head_q;
        end

        brp_update_d = retire && (hd.op == OP_BRANCH);
        brp_addr_d   = brp_addr_q;
        brp_result_d = brp_result_q;
        if (brp_update_d) begin
            brp_addr_d   = hd.baddr;
            brp_result_d = hd.taken;
        end

        pc_modify_d = flush;
        npc_d       = flush ? hd.npc : npc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_modify_q <= 1'b0;
            reg_name_q   <= '0;
            reg_data_q   <= '0;
            reg_tag_q    <= '0;
            pc_modify_q  <= 1'b0;
            npc_q        <= '0;
            brp_update_q <= 1'b0;
            brp_addr_q   <= '0;
            brp_result_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_modify_q <= reg_modify_d;
            reg_name_q   <= reg_name_d;
            reg_data_q   <= reg_data_d;
            reg_tag_q    <= reg_tag_d;
            pc_modify_q  <= pc_modify_d;
            npc_q        <= npc_d;
            brp_update_q <= brp_update_d;
            brp_addr_q   <= brp_addr_d;
            brp_result_q <= brp_result_d;
        end
    end

    // ---------------- check ports ----------------
    always_comb begin
        {bus.chk_rdy1, bus.chk_val1} = lookup(bus.chk_tag1);
        {bus.chk_rdy2, bus.chk_val2} = lookup(bus.chk_tag2);
    end

    // ---------------- output drive ----------------
    assign bus.alloc_ready  = alloc_ready;
    assign bus.alloc_tag    = tail_q;
    assign bus.full         = full;

    assign bus.dcache_write = store_go;
    assign bus.dcache_mask  = store_go ? st_mask : 4'b0000;
    assign bus.dcache_addr  = store_go ? {hd.addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.dcache_data  = store_go ? (hd.value << {lane, 3'b000}) : '0;

    assign bus.reg_modify   = reg_modify_q;
    assign bus.reg_name     = reg_name_q;
    assign bus.reg_data     = reg_data_q;
    assign bus.reg_tag      = reg_tag_q;
    assign bus.pc_modify    = pc_modify_q;
    assign bus.npc          = npc_q;
    assign bus.brp_update   = brp_update_q;
    assign bus.brp_addr     = brp_addr_q;
    assign bus.brp_result   = brp_result_q;
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: store mask/shift table plus hand-written commit,
// bypass, flush and reset sequences.
module tb_rob_param;
    localparam int DEPTH = 8, TAG_W = 3, DATA_W = 32, ADDR_W = 32;
    localparam int REG_W = 5, BRA_W = 8, NUM_CDB = 2;

    localparam logic [2:0] OP_BRANCH = 3'd1, OP_NORMAL = 3'd2;
    localparam logic [2:0] OP_SB = 3'd3, OP_SH = 3'd4, OP_SW = 3'd5;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
        logic        exp_wr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } st_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [2:0] model_tail;
    st_vec_t vecs [9];

    always #5 clk = ~clk;

    rob_param_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W),
                   .BRA_W(BRA_W), .NUM_CDB(NUM_CDB)) bus ();

    rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                .REG_W(REG_W), .BRA_W(BRA_W), .NUM_CDB(NUM_CDB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid  = 1'b0;
        bus.alloc_op     = 3'd0;
        bus.alloc_rd     = '0;
        bus.alloc_npc    = '0;
        bus.alloc_baddr  = '0;
        bus.chk_tag1     = '0;
        bus.chk_tag2     = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.cdb_addr     = '0;
        bus.bra_valid    = 1'b0;
        bus.bra_tag      = '0;
        bus.bra_taken    = 1'b0;
        bus.bra_mispred  = 1'b0;
        bus.dcache_ready = 1'b0;
    endtask

    task automatic cdb_drive(input int ch, input logic [2:0] tag, input logic [31:0] val,
                             input logic [31:0] addr);
        bus.cdb_valid[ch]             = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W] = tag;
        bus.cdb_value[ch*DATA_W +: DATA_W] = val;
        bus.cdb_addr[ch*ADDR_W +: ADDR_W]  = addr;
    endtask

    task automatic alloc(input logic [2:0] op, input logic [4:0] rd, input logic [31:0] npc,
                         input logic [7:0] baddr);
        bus.alloc_valid = 1'b1;
        bus.alloc_op    = op;
        bus.alloc_rd    = rd;
        bus.alloc_npc   = npc;
        bus.alloc_baddr = baddr;
        #1;
        chk("alloc_tag", 64'(bus.alloc_tag), 64'(model_tail));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(1));
        tick();
        bus.alloc_valid = 1'b0;
        model_tail++;
    endtask

    task automatic check_store(input int v);
        chk("dcache_write", 64'(bus.dcache_write), 64'(vecs[v].exp_wr));
        if (vecs[v].exp_wr) begin
            chk("dcache_mask", 64'(bus.dcache_mask), 64'(vecs[v].exp_mask));
            chk("dcache_addr", 64'(bus.dcache_addr), 64'(vecs[v].exp_addr));
            chk("dcache_data", 64'(bus.dcache_data), 64'(vecs[v].exp_data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        logic [2:0] btag;
        logic [2:0] ytag;

        vecs[0] = '{OP_SB, 32'h1003, 32'h55,       3, 1'b1, 4'b1000, 32'h1000, 32'h5500_0000};
        vecs[1] = '{OP_SB, 32'h2000, 32'hAB,       0, 1'b1, 4'b0001, 32'h2000, 32'h0000_00AB};
        vecs[2] = '{OP_SB, 32'h2001, 32'hAB,       0, 1'b1, 4'b0010, 32'h2000, 32'h0000_AB00};
        vecs[3] = '{OP_SB, 32'h2002, 32'hAB,       0, 1'b1, 4'b0100, 32'h2000, 32'h00AB_0000};
        vecs[4] = '{OP_SH, 32'h3000, 32'hBEEF,     0, 1'b1, 4'b0011, 32'h3000, 32'h0000_BEEF};
        vecs[5] = '{OP_SH, 32'h3002, 32'hBEEF,     0, 1'b1, 4'b1100, 32'h3000, 32'hBEEF_0000};
        vecs[6] = '{OP_SH, 32'h3001, 32'hBEEF,     0, 1'b0, 4'b0000, 32'h0,    32'h0};
        vecs[7] = '{OP_SW, 32'h4000, 32'hDEADBEEF, 0, 1'b1, 4'b1111, 32'h4000, 32'hDEAD_BEEF};
        vecs[8] = '{OP_SW, 32'h4002, 32'hDEADBEEF, 0, 1'b0, 4'b0000, 32'h0,    32'h0};

        idle();
        rst = 1'b0;
        model_tail = 3'd0;
        #12;
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'(1));
        chk("rst_full", 64'(bus.full), 64'(0));
        chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'(0));
        chk("rst_reg_modify", 64'(bus.reg_modify), 64'(0));
        chk("rst_pc_modify", 64'(bus.pc_modify), 64'(0));
        chk("rst_npc", 64'(bus.npc), 64'(0));
        chk("rst_brp_update", 64'(bus.brp_update), 64'(0));
        chk("rst_dcache_write", 64'(bus.dcache_write), 64'(0));
        chk("rst_chk_rdy1", 64'(bus.chk_rdy1), 64'(0));
        rst = 1'b1;
        tick();

        // fill the queue
        for (int i = 0; i < 8; i++) alloc(OP_NORMAL, 5'(i + 1), 32'h0, 8'h0);
        #1;
        chk("fill_full", 64'(bus.full), 64'(1));
        chk("fill_alloc_ready", 64'(bus.alloc_ready), 64'(0));
        chk("fill_alloc_tag_wrap", 64'(bus.alloc_tag), 64'(0));

        // first commit through CDB0, with bypass on the check port
        cdb_drive(0, 3'd0, 32'h1234, 32'h0);
        bus.chk_tag1 = 3'd0;
        #1;
        chk("bypass_val", 64'(bus.chk_val1), 64'(32'h1234));
        chk("bypass_rdy", 64'(bus.chk_rdy1), 64'(1));
        tick();
        idle();
        #1;
        chk("commit0_full_before", 64'(bus.full), 64'(1));
        chk("commit0_no_pulse_yet", 64'(bus.reg_modify), 64'(0));
        tick();
        chk("commit0_reg_modify", 64'(bus.reg_modify), 64'(1));
        chk("commit0_reg_data", 64'(bus.reg_data), 64'(32'h1234));
        chk("commit0_reg_tag", 64'(bus.reg_tag), 64'(0));
        chk("commit0_reg_name", 64'(bus.reg_name), 64'(1));
        chk("commit0_full_after", 64'(bus.full), 64'(0));
        tick();
        chk("commit0_pulse_end", 64'(bus.reg_modify), 64'(0));

        // two channels to the same tag: channel 0 wins
        cdb_drive(0, 3'd3, 32'hA, 32'h0);
        cdb_drive(1, 3'd3, 32'hB, 32'h0);
        bus.chk_tag1 = 3'd3;
        bus.chk_tag2 = 3'd3;
        #1;
        chk("dual_bypass_val1", 64'(bus.chk_val1), 64'(32'hA));
        chk("dual_bypass_rdy1", 64'(bus.chk_rdy1), 64'(1));
        chk("dual_bypass_val2", 64'(bus.chk_val2), 64'(32'hA));
        tick();
        idle();
        bus.chk_tag1 = 3'd3;
        bus.chk_tag2 = 3'd2;
        #1;
        chk("dual_stored_val", 64'(bus.chk_val1), 64'(32'hA));
        chk("dual_stored_rdy", 64'(bus.chk_rdy1), 64'(1));
        chk("pending_rdy2", 64'(bus.chk_rdy2), 64'(0));

        // drain: tags 1..7 retire one per cycle, last pulse is tag 7
        cdb_drive(0, 3'd1, 32'h11, 32'h0);
        cdb_drive(1, 3'd2, 32'h22, 32'h0);
        tick(); idle();
        cdb_drive(0, 3'd4, 32'h44, 32'h0);
        cdb_drive(1, 3'd5, 32'h55, 32'h0);
        tick(); idle();
        cdb_drive(0, 3'd6, 32'h66, 32'h0);
        cdb_drive(1, 3'd7, 32'h77, 32'h0);
        tick(); idle();
        repeat (5) tick();
        chk("drain_reg_modify", 64'(bus.reg_modify), 64'(1));
        chk("drain_reg_tag", 64'(bus.reg_tag), 64'(7));
        chk("drain_reg_data", 64'(bus.reg_data), 64'(32'h77));
        chk("drain_reg_name", 64'(bus.reg_name), 64'(8));
        tick();
        chk("drain_pulse_end", 64'(bus.reg_modify), 64'(0));

        // store mask/shift table
        for (int v = 0; v < 9; v++) begin
            t = model_tail;
            alloc(vecs[v].op, 5'd0, 32'h0, 8'h0);
            cdb_drive(0, t, vecs[v].data, vecs[v].addr);
            bus.dcache_ready = 1'b0;
            tick();
            idle();
            bus.chk_tag1 = t;
            #1;
            for (int h = 0; h < vecs[v].hold; h++) begin
                check_store(v);
                chk("store_held", 64'(bus.chk_rdy1), 64'(1));
                tick();
            end
            bus.dcache_ready = 1'b1;
            #1;
            check_store(v);
            tick();
            bus.dcache_ready = 1'b0;
            #1;
            chk("store_retired", 64'(bus.chk_rdy1), 64'(0));
            chk("store_write_off", 64'(bus.dcache_write), 64'(0));
            chk("store_no_reg", 64'(bus.reg_modify), 64'(0));
        end

        // mispredicted branch with three younger entries
        btag = model_tail;
        ytag = btag + 3'd2;
        alloc(OP_BRANCH, 5'd0, 32'h40, 8'h5A);
        for (int i = 0; i < 3; i++) alloc(OP_NORMAL, 5'(10 + i), 32'h0, 8'h0);
        bus.bra_valid   = 1'b1;
        bus.bra_tag     = btag;
        bus.bra_taken   = 1'b1;
        bus.bra_mispred = 1'b1;
        tick();
        idle();
        cdb_drive(0, ytag, 32'h99, 32'h0);
        #1;
        chk("flush_alloc_ready", 64'(bus.alloc_ready), 64'(0));
        tick();
        idle();
        bus.chk_tag1 = ytag;
        #1;
        chk("flush_pc_modify", 64'(bus.pc_modify), 64'(1));
        chk("flush_npc", 64'(bus.npc), 64'(32'h40));
        chk("flush_brp_update", 64'(bus.brp_update), 64'(1));
        chk("flush_brp_addr", 64'(bus.brp_addr), 64'(8'h5A));
        chk("flush_brp_result", 64'(bus.brp_result), 64'(1));
        chk("flush_no_reg", 64'(bus.reg_modify), 64'(0));
        chk("flush_full", 64'(bus.full), 64'(0));
        chk("flush_alloc_ready_after", 64'(bus.alloc_ready), 64'(1));
        chk("flush_younger_dropped", 64'(bus.chk_rdy1), 64'(0));
        model_tail = btag + 3'd1;
        chk("flush_alloc_tag", 64'(bus.alloc_tag), 64'(model_tail));
        tick();
        chk("flush_pc_pulse_end", 64'(bus.pc_modify), 64'(0));
        chk("flush_brp_pulse_end", 64'(bus.brp_update), 64'(0));

        // correctly predicted branch
        btag = model_tail;
        alloc(OP_BRANCH, 5'd0, 32'h80, 8'h33);
        bus.bra_valid   = 1'b1;
        bus.bra_tag     = btag;
        bus.bra_taken   = 1'b0;
        bus.bra_mispred = 1'b0;
        tick();
        idle();
        tick();
        chk("br_ok_brp_update", 64'(bus.brp_update), 64'(1));
        chk("br_ok_brp_addr", 64'(bus.brp_addr), 64'(8'h33));
        chk("br_ok_brp_result", 64'(bus.brp_result), 64'(0));
        chk("br_ok_no_redirect", 64'(bus.pc_modify), 64'(0));
        tick();
        chk("br_ok_pulse_end", 64'(bus.brp_update), 64'(0));

        // reset during a pending store with a full queue
        t = model_tail;
        alloc(OP_SW, 5'd0, 32'h0, 8'h0);
        for (int i = 0; i < 7; i++) alloc(OP_NORMAL, 5'(20 + i), 32'h0, 8'h0);
        #1;
        chk("pre_rst_full", 64'(bus.full), 64'(1));
        cdb_drive(0, t, 32'h1, 32'h8000);
        tick();
        idle();
        #1;
        chk("pre_rst_dcache_write", 64'(bus.dcache_write), 64'(1));
        chk("pre_rst_dcache_mask", 64'(bus.dcache_mask), 64'(4'b1111));
        chk("pre_rst_dcache_addr", 64'(bus.dcache_addr), 64'(32'h8000));
        rst = 1'b0;
        #1;
        chk("mid_rst_dcache_write", 64'(bus.dcache_write), 64'(0));
        chk("mid_rst_dcache_mask", 64'(bus.dcache_mask), 64'(0));
        chk("mid_rst_dcache_addr", 64'(bus.dcache_addr), 64'(0));
        chk("mid_rst_full", 64'(bus.full), 64'(0));
        chk("mid_rst_alloc_tag", 64'(bus.alloc_tag), 64'(0));
        chk("mid_rst_reg_data", 64'(bus.reg_data), 64'(0));
        chk("mid_rst_npc", 64'(bus.npc), 64'(0));
        chk("mid_rst_brp_addr", 64'(bus.brp_addr), 64'(0));
        #2;
        rst = 1'b1;
        model_tail = 3'd0;
        tick();
        chk("post_rst_alloc_tag", 64'(bus.alloc_tag), 64'(0));
        chk("post_rst_alloc_ready", 64'(bus.alloc_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer: circular queue of DEPTH entries holding in-flight instructions from decode until in-order commit.
- Accepts results from NUM_CDB common-data-bus channels and one branch unit; retires one entry per cycle to the register file, data cache (stores) and branch predictor.
- On a committed mispredicted branch, flushes every younger entry and redirects the PC.
- Serves two operand-check ports, each with same-cycle CDB bypass.

Parameters:
- DEPTH, 8, number of entries; power of two, >=2.
- TAG_W, 3, log2(DEPTH); entry tag width.
- DATA_W, 32, result/store data width.
- ADDR_W, 32, memory and instruction address width.
- REG_W, 5, architectural register index width.
- BRA_W, 8, branch-predictor index width.
- NUM_CDB, 2, number of CDB write-back channels.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  decode requests an entry.
- alloc_ready  out  1  equals !full && !flush.
- alloc_op  in  3  operation: 1 = branch, 2 = normal, 3/4/5 = store byte/half/word; 0 is illegal.
- alloc_rd  in  REG_W  destination register.
- alloc_npc  in  ADDR_W  redirect PC used if the branch mispredicts.
- alloc_baddr  in  BRA_W  predictor index.
- alloc_tag  out  TAG_W  tail pointer; the tag given to the next allocation.
- full  out  1  count == DEPTH.
- chk_tag1, chk_tag2  in  TAG_W  operand lookup tags.
- chk_val1, chk_val2  out  DATA_W  looked-up value.
- chk_rdy1, chk_rdy2  out  1  value valid.
- cdb_valid  in  NUM_CDB  per-channel write strobe.
- cdb_tag  in  NUM_CDB*TAG_W  packed tags.
- cdb_value  in  NUM_CDB*DATA_W  packed results or store data.
- cdb_addr  in  NUM_CDB*ADDR_W  packed store addresses.
- bra_valid  in  1  branch resolution strobe.
- bra_tag  in  TAG_W  tag of the resolved branch.
- bra_taken  in  1  resolved direction.
- bra_mispred  in  1  prediction was wrong.
- reg_modify  out  1  registered register-write pulse.
- reg_name  out  REG_W  destination register.
- reg_data  out  DATA_W  value to write.
- reg_tag  out  TAG_W  tag of the committing entry.
- dcache_write  out  1  store request.
- dcache_mask  out  4  byte-lane mask.
- dcache_addr  out  ADDR_W  word-aligned address.
- dcache_data  out  DATA_W  lane-shifted data.
- dcache_ready  in  1  cache accepts the store this cycle.
- pc_modify  out  1  registered redirect pulse.
- npc  out  ADDR_W  redirect target.
- brp_update  out  1  registered predictor-update pulse.
- brp_addr  out  BRA_W  predictor index.
- brp_result  out  1  resolved direction.

Behaviour:
- Reset (async, rst low): head = tail = 0, count = 0, all busy/ready bits = 0. Every registered output is 0: reg_*, pc_modify, npc, brp_*.
- Pointers wrap modulo DEPTH. count is TAG_W+1 bits so that DEPTH is representable.
- Allocate when alloc_valid && alloc_ready:
  - Write the fields to entry[tail]; set busy = 1, ready = 0; tail += 1.
  - The entry becomes visible to CDB and check ports from the next cycle.
- Write-back:
  - CDB channel i with cdb_valid[i] sets entry[tag].ready = 1 and value = cdb_value. If the entry op is a store, it also sets addr = cdb_addr.
  - Writes are ignored if the entry is not busy or is already ready.
  - If several channels hit the same tag, the lowest index wins.
  - bra_valid sets ready, taken and mispred under the same rules.
  - All write-back updates land at the clock edge.
- Check ports (combinational):
  - If any CDB channel writes chk_tag this cycle, return its value with rdy = 1 (lowest index wins).
  - Otherwise return entry value and (busy && ready).
- Commit eligibility: head_ok = count != 0 && entry[head].busy && entry[head].ready.
  - normal: retire. Next cycle reg_modify = 1 with reg_name, reg_data and reg_tag = head.
  - branch: retire. Next cycle brp_update = 1 with brp_addr and brp_result = taken.
    - If mispred: flush this cycle; next cycle pc_modify = 1 and npc = the entry's npc.
  - store: dcache_write, mask, addr and data are combinational from head while head_ok.
    - Retire only in the cycle dcache_ready = 1; otherwise hold.
    - dcache_addr = addr with bits [1:0] cleared.
    - Mask/shift by op and addr[1:0]:
      - byte: 0001 / 0010 / 0100 / 1000, data << 8*addr[1:0].
      - half, addr[1:0] = 00: 0011, data unshifted.
      - half, addr[1:0] = 10: 1100, data << 16.
      - word, addr[1:0] = 00: 1111, data unshifted.
    - Misaligned store: dcache_write = 0 and the entry retires silently (no cache write).
- Retire: entry[head].busy = 0; head += 1.
- Simultaneous allocate and retire: count unchanged; both pointers advance. Allocate is legal when full only if retire happens the same cycle — not allowed: alloc_ready = !full.
- Flush (mispredicted branch retiring):
  - All busy bits cleared; tail = head+1; count = 0.
  - alloc_ready = 0 in that cycle, so no allocation is taken.
  - CDB writes in that cycle are dropped.
- All registered commit pulses last exactly one cycle.
- Reset mid-store: dcache_write drops immediately (it is combinational from cleared state).

Test Plan:
- Allocate 8 normal ops (DEPTH = 8) -> full = 1 and alloc_ready = 0 after the 8th; alloc_tag wraps to 0.
- CDB0 writes tag 0 value 0x1234 while entry 0 is at head -> next cycle reg_modify = 1, reg_data = 0x1234, reg_tag = 0; count decrements.
- CDB0 and CDB1 both target tag 3 with 0xA and 0xB -> entry value = 0xA. A same-cycle check of tag 3 returns 0xA with rdy = 1.
- Store byte with addr 0x1003, data 0x55, dcache_ready held 0 for 3 cycles then 1:
  - dcache_mask = 1000, dcache_addr = 0x1000, data = 0x55000000 held for 4 cycles.
  - Retires on the 4th.
- Branch at head with mispred = 1, npc = 0x40, with 3 younger entries -> next cycle pc_modify = 1, npc = 0x40, brp_update = 1; count = 0; younger CDB writes ignored.
- Assert rst low during a pending store and full queue -> all outputs 0 immediately; after release alloc_tag = 0 and alloc_ready = 1.
